// File: rtl/irq_arbiter_8.sv
// Eight-source interrupt arbiter: per-source polarity/edge capture, masking,
// fixed priority (bit 0 highest) and nested in-service tracking.

module irq_src_lane #(
  parameter logic POL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic irq,
  input  logic ack_clr,
  output logic pend
);
  logic corr, prev, rise;

  assign corr = irq ^ POL;
  assign rise = corr & ~prev;

  // A rising edge outranks a same-cycle ack so a back-to-back event is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= corr;
      pend <= 1'b0;
    end else begin
      prev <= corr;
      pend <= rise | (pend & ~ack_clr);
    end
  end
endmodule

module irq_arbiter_8 #(
  parameter logic [7:0] POLARITY_MASK = 8'h00,
  parameter logic [7:0] MASK_RESET    = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] irq_in,
  input  logic       int_en,
  input  logic       mask_we,
  input  logic [7:0] mask_wdata,
  input  logic       int_ack,
  input  logic       eret,
  output logic       int_req,
  output logic [2:0] int_id,
  output logic [7:0] pending,
  output logic [7:0] in_service,
  output logic [7:0] mask
);
  localparam int NUM_SRC = 8;

  typedef enum logic {IDLE, REQ} state_t;
  state_t state;

  // Index of the lowest set bit; 8 when none is set.
  function automatic logic [3:0] lowest(input logic [7:0] v);
    lowest = 4'd8;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (v[i]) lowest = i[3:0];
  endfunction

  logic [7:0] elig, ack_clr, eret_clr, mask_nxt;
  logic [3:0] cand, cur;
  logic       ack_hit, qual, withdraw;

  assign elig     = int_en ? (pending & ~mask) : 8'h00;
  assign cand     = lowest(elig);
  assign cur      = lowest(in_service);
  assign qual     = cand < cur;
  assign ack_hit  = (state == REQ) && int_ack;
  assign ack_clr  = ack_hit ? (8'd1 << int_id) : 8'h00;
  assign eret_clr = (eret && cur != 4'd8) ? (8'd1 << cur[2:0]) : 8'h00;
  assign mask_nxt = mask_we ? mask_wdata : mask;
  assign withdraw = !int_en || mask_nxt[int_id];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
    irq_src_lane #(.POL(POLARITY_MASK[g])) u_lane (
      .clk     (clk),
      .rst     (rst),
      .irq     (irq_in[g]),
      .ack_clr (ack_clr[g]),
      .pend    (pending[g])
    );
  end

  // eret retires the old top of the nest before the ack pushes the new one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      int_req    <= 1'b0;
      int_id     <= 3'd0;
      in_service <= 8'h00;
      mask       <= MASK_RESET;
    end else begin
      mask       <= mask_nxt;
      in_service <= (in_service & ~eret_clr) | ack_clr;
      case (state)
        IDLE: if (qual) begin
          int_id  <= cand[2:0];
          int_req <= 1'b1;
          state   <= REQ;
        end
        REQ: if (ack_hit || withdraw) begin
          int_req <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
